ps2_keycode_rx: RTL



---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_hid_map.sv | 29 ++
 rtl/ps2_keycode_rx.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 keycode receiver.
// Frame FSM states, scancode prefixes and HID usage codes.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_RIGHT = 8'h4F;
    localparam logic [7:0] HID_UP    = 8'h52;
    localparam logic [7:0] HID_DOWN  = 8'h51;

    // Odd parity holds when data plus parity bit carry an odd count of ones.
    function automatic logic odd_ones(input logic [8:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/ps2_hid_map.sv
// ps2_hid_map: Set-2 make code (with E0 flag) to HID usage code.
// Codes not in the table map to 0 so the decoder ignores them.
module ps2_hid_map
    import ps2_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] data,
    output logic [7:0] code
);

    // Table lookup on {extended flag, scancode byte}.
    always_comb begin
        code = 8'h00;
        case ({ext, data})
            9'h01C:  code = HID_A;
            9'h023:  code = HID_D;
            9'h01D:  code = HID_W;
            9'h01B:  code = HID_S;
            9'h029:  code = HID_SPACE;
            9'h05A:  code = HID_ENTER;
            9'h16B:  code = HID_LEFT;
            9'h174:  code = HID_RIGHT;
            9'h175:  code = HID_UP;
            9'h172:  code = HID_DOWN;
            default: code = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 Set-2 frame receiver and held-key decoder.
// Define PS2_TRANSLATE_EN to translate scancodes to HID usage codes.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 10000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_s1;
    logic          clk_s2;
    logic          dat_s1;
    logic          dat_s2;
    logic          filt;
    logic          filt_d;
    logic [FW-1:0] fcnt;
    logic          strb;
    logic [TW-1:0] tmo;
    ps2_state_t    state;
    logic [2:0]    bcnt;
    logic [7:0]    shreg;
    logic          par;
    logic          ext;
    logic          brk;
    logic [7:0]    code;

    // Two-flop synchronizers; pins idle high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock flips only after FILTER_LEN opposite samples in a row.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            filt_d <= filt;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign strb = filt_d & ~filt;

    // Watchdog reloads on every bit strobe and counts down otherwise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tmo <= TW'(TIMEOUT_CYC);
        end else if (strb) begin
            tmo <= TW'(TIMEOUT_CYC);
        end else if (tmo != '0) begin
            tmo <= tmo - 1'b1;
        end
    end

    // Frame FSM: start, 8 data bits LSB first, parity, stop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            bcnt      <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (strb) begin
                unique case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state <= DATA;
                            bcnt  <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg <= {dat_s2, shreg[7:1]};
                        bcnt  <= bcnt + 1'b1;
                        if (bcnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat_s2;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (dat_s2 && odd_ones({par, shreg})) begin
                            rx_byte  <= shreg;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end else if (state != IDLE && tmo == '0) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end

`ifdef PS2_TRANSLATE_EN
    ps2_hid_map u_map (
        .ext  (ext),
        .data (rx_byte),
        .code (code)
    );
`else
    logic ext_unused;
    assign ext_unused = ext;
    assign code       = rx_byte;
`endif

    // Prefix tracking and held-key update; newest press wins.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            keycode   <= '0;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (frame_err) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_valid) begin
                unique case (1'b1)
                    (rx_byte == PS2_EXT): ext <= 1'b1;
                    (rx_byte == PS2_BRK): brk <= 1'b1;
                    default: begin
                        ext <= 1'b0;
                        brk <= 1'b0;
                        if (brk) begin
                            if (code == keycode) begin
                                keycode   <= '0;
                                key_event <= 1'b1;
                            end
                        end else if (code != 8'h00) begin
                            keycode   <= code;
                            key_event <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
